// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register specifier and the hazard controller
// state encoding.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        LU2        = 2'b01,
        FLUSH_PEND = 2'b10
    } lc3b_hz_state;

    // True when an ID source operand is read and names the EX destination.
    function automatic logic src_match(input logic uses, input lc3b_reg src, input lc3b_reg dest);
        return uses & (src == dest);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Only built when HAZARD_PERF_CNT_EN is defined, since nothing else uses it.
`ifdef HAZARD_PERF_CNT_EN
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: hold at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/hazard_ctrl.sv
// LC-3b pipeline hazard controller: stalls, bubbles, flushes and PC redirect.
// Optional counters enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  lc3b_reg          id_sr1_id,
    input  lc3b_reg          id_sr2_id,
    input  logic             id_uses_sr1,
    input  logic             id_uses_sr2,
    input  lc3b_reg          ex_dest,
    input  logic             ex_load_regfile,
    input  logic             ex_mem_read,
    input  logic             if_mem_req,
    input  logic             if_mem_resp,
    input  logic             mem_mem_req,
    input  logic             mem_mem_resp,
    input  logic             mem_br_taken,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             id_ex_bubble,
    output logic             mem_wb_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_redirect,
    output logic             target_latch_en,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    lc3b_hz_state state_q;
    lc3b_hz_state state_d;
    logic         dmiss_s;
    logic         ibusy_s;
    logic         lu_hit_s;

    assign dmiss_s  = mem_mem_req & ~mem_mem_resp;
    assign ibusy_s  = if_mem_req & ~if_mem_resp;
    assign lu_hit_s = ex_mem_read & ex_load_regfile &
                      (src_match(id_uses_sr1, id_sr1_id, ex_dest) |
                       src_match(id_uses_sr2, id_sr2_id, ex_dest));

    // Mealy control: outputs and next state from state plus current inputs.
    always_comb begin
        pc_stall        = 1'b0;
        if_id_stall     = 1'b0;
        id_ex_stall     = 1'b0;
        ex_mem_stall    = 1'b0;
        id_ex_bubble    = 1'b0;
        mem_wb_bubble   = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_mem_flush    = 1'b0;
        pc_redirect     = 1'b0;
        target_latch_en = 1'b0;
        state_d         = state_q;
        if (reset) begin
            state_d = RUN;
        end else if (dmiss_s) begin
            target_latch_en = mem_br_taken;
            pc_stall        = 1'b1;
            if_id_stall     = 1'b1;
            id_ex_stall     = 1'b1;
            ex_mem_stall    = 1'b1;
            mem_wb_bubble   = 1'b1;
            // A pending redirect still completes when the fetch returns.
            if ((state_q == FLUSH_PEND) && if_mem_resp) begin
                pc_redirect = 1'b1;
                if_id_flush = 1'b1;
                state_d     = RUN;
            end else begin
                state_d = state_q;
            end
        end else begin
            target_latch_en = mem_br_taken;
            case (state_q)
                FLUSH_PEND: begin
                    if (if_mem_resp) begin
                        pc_redirect = 1'b1;
                        if_id_flush = 1'b1;
                        state_d     = RUN;
                    end else begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                RUN, LU2: begin
                    if (mem_br_taken) begin
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        // With a fetch in flight, wait for it before redirecting.
                        if (ibusy_s) begin
                            pc_stall    = 1'b1;
                            if_id_stall = 1'b1;
                            state_d     = FLUSH_PEND;
                        end else begin
                            pc_redirect = 1'b1;
                            if_id_flush = 1'b1;
                            state_d     = RUN;
                        end
                    end else if ((state_q == LU2) || lu_hit_s) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        state_d      = (state_q == LU2) ? RUN : LU2;
                    end else if (ibusy_s) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush),
        .count (flush_events)
    );
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle vector table through a
// scoreboard queue, plus reset and counter sequences.
module tb_hazard_ctrl;
    import lc3b_types::*;

    localparam int CNT_W = 4;

    // Output vector bit weights (packed order of outs_s below).
    localparam logic [10:0] E_NONE  = 11'h000;
    localparam logic [10:0] E_LU    = 11'h640; // pc, if_id stall, id_ex bubble
    localparam logic [10:0] E_DMISS = 11'h7A0; // four stalls + mem_wb bubble
    localparam logic [10:0] E_BR    = 11'h01F; // redirect, 3 flushes, latch
    localparam logic [10:0] E_BRBSY = 11'h60D; // 2 flushes, front stall, latch
    localparam logic [10:0] E_RESP  = 11'h012; // redirect + if_id flush

    typedef struct packed {
        lc3b_reg sr1;
        lc3b_reg sr2;
        logic    u1;
        logic    u2;
        lc3b_reg dest;
        logic    ld;
        logic    rd;
        logic    ireq;
        logic    iresp;
        logic    mreq;
        logic    mresp;
        logic    br;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic [10:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    lc3b_reg id_sr1_id, id_sr2_id, ex_dest;
    logic id_uses_sr1, id_uses_sr2, ex_load_regfile, ex_mem_read;
    logic if_mem_req, if_mem_resp, mem_mem_req, mem_mem_resp, mem_br_taken;
    logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble, mem_wb_bubble;
    logic if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect, target_latch_en;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    logic [10:0] outs_s;

    int nchecks = 0;
    int nerrors = 0;
    logic [10:0] exp_q[$];
    string       name_q[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_sr1_id(id_sr1_id), .id_sr2_id(id_sr2_id),
        .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
        .ex_dest(ex_dest), .ex_load_regfile(ex_load_regfile), .ex_mem_read(ex_mem_read),
        .if_mem_req(if_mem_req), .if_mem_resp(if_mem_resp),
        .mem_mem_req(mem_mem_req), .mem_mem_resp(mem_mem_resp),
        .mem_br_taken(mem_br_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
        .id_ex_bubble(id_ex_bubble), .mem_wb_bubble(mem_wb_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .pc_redirect(pc_redirect), .target_latch_en(target_latch_en),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    assign outs_s = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, id_ex_bubble,
                     mem_wb_bubble, if_id_flush, id_ex_flush, ex_mem_flush,
                     pc_redirect, target_latch_en};

    task automatic drive(input in_t i);
        id_sr1_id       = i.sr1;
        id_sr2_id       = i.sr2;
        id_uses_sr1     = i.u1;
        id_uses_sr2     = i.u2;
        ex_dest         = i.dest;
        ex_load_regfile = i.ld;
        ex_mem_read     = i.rd;
        if_mem_req      = i.ireq;
        if_mem_resp     = i.iresp;
        mem_mem_req     = i.mreq;
        mem_mem_resp    = i.mresp;
        mem_br_taken    = i.br;
    endtask

    task automatic check_val(input string nm, input int got, input int expv);
        nchecks++;
        if (got != expv) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic apply(input in_t i, input logic [10:0] e, input string nm);
        logic [10:0] ev;
        string       en;
        drive(i);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        ev = exp_q.pop_front();
        en = name_q.pop_front();
        nchecks++;
        if (outs_s !== ev) begin
            nerrors++;
            $display("FAIL %s: outputs got %b expected %b", en, outs_s, ev);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    in_t IDLE, LUH1, LUH2, LUNO1, LUNO2, DMISS, DHIT, BR, BRBSY, IBUSY, IRESP, DRESP, DBR;
    int exp_stall, exp_flush;

    initial begin
        IDLE = '0;
        LUH1 = IDLE; LUH1.rd = 1'b1; LUH1.ld = 1'b1; LUH1.dest = 3'd3; LUH1.sr1 = 3'd3; LUH1.u1 = 1'b1;
        LUH2 = IDLE; LUH2.rd = 1'b1; LUH2.ld = 1'b1; LUH2.dest = 3'd5; LUH2.sr2 = 3'd5; LUH2.u2 = 1'b1;
        LUNO1 = LUH1; LUNO1.u1 = 1'b0;             // register matches but not read
        LUNO2 = LUH1; LUNO2.ld = 1'b0;             // load without regfile write
        DMISS = IDLE; DMISS.mreq = 1'b1;
        DHIT  = DMISS; DHIT.mresp = 1'b1;
        BR    = IDLE; BR.br = 1'b1;
        IBUSY = IDLE; IBUSY.ireq = 1'b1;
        BRBSY = IBUSY; BRBSY.br = 1'b1;
        IRESP = IBUSY; IRESP.iresp = 1'b1;
        DRESP = IRESP; DRESP.mreq = 1'b1;
        DBR   = DMISS; DBR.br = 1'b1;

        // Reset with aggressive inputs: everything must read zero.
        drive(DBR);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply(DBR, E_NONE, "reset_outputs");
        apply(LUH1, E_NONE, "reset_outputs_lu");
        check_val("reset_stall_cnt", int'(stall_cycles), 0);
        check_val("reset_flush_cnt", int'(flush_events), 0);
        reset = 1'b0;

        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{LUH1,  E_LU});     // load-use: 2 bubbles then clear
        vecs.push_back('{IDLE,  E_LU});
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{LUH2,  E_LU});     // via SR2, then 5-cycle dmiss in LU2
        for (int k = 0; k < 5; k++) vecs.push_back('{DMISS, E_DMISS});
        vecs.push_back('{IDLE,  E_LU});
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{LUNO1, E_NONE});
        vecs.push_back('{LUNO2, E_NONE});
        vecs.push_back('{DHIT,  E_NONE});
        vecs.push_back('{BR,    E_BR});     // idle icache: redirect, stay RUN
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{BRBSY, E_BRBSY});  // busy icache: resp after 4 cycles
        for (int k = 0; k < 3; k++) vecs.push_back('{IBUSY, E_LU});
        vecs.push_back('{IRESP, E_RESP});
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{IBUSY, E_LU});     // plain fetch stall
        vecs.push_back('{LUH1,  E_LU});     // branch in LU2 drops the bubble
        vecs.push_back('{BR,    E_BR});
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{BRBSY, E_BRBSY});  // redirect completes under dmiss
        vecs.push_back('{DRESP, E_DMISS | E_RESP});
        vecs.push_back('{IDLE,  E_NONE});
        vecs.push_back('{DBR,   E_DMISS | 11'h001}); // dmiss outranks branch
        vecs.push_back('{IDLE,  E_NONE});

        for (int n = 0; n < vecs.size(); n++) begin
            apply(vecs[n].i, vecs[n].e, $sformatf("vec%0d", n));
        end

        // Reset during FLUSH_PEND abandons the redirect.
        apply(BRBSY, E_BRBSY, "fp_enter");
        reset = 1'b1;
        apply(IRESP, E_NONE, "fp_in_reset");
        reset = 1'b0;
        apply(IRESP, E_NONE, "fp_after_reset");
        check_val("fp_no_redirect", int'(pc_redirect), 0);

        // Reset during LU2 abandons the second bubble.
        apply(LUH1, E_LU, "lu_enter");
        reset = 1'b1;
        apply(IDLE, E_NONE, "lu_in_reset");
        reset = 1'b0;
        apply(IDLE, E_NONE, "lu_after_reset");

        // Performance counters.
`ifdef HAZARD_PERF_CNT_EN
        exp_stall = 15;
        exp_flush = 3;
`else
        exp_stall = 0;
        exp_flush = 0;
`endif
        do_reset();
        for (int k = 0; k < 3; k++) apply(BR, E_BR, "cnt_br");
        check_val("flush_events", int'(flush_events), exp_flush);
        check_val("stall_after_br", int'(stall_cycles), 0);
        for (int k = 0; k < 20; k++) apply(IBUSY, E_LU, "cnt_stall");
        check_val("stall_cycles_sat", int'(stall_cycles), exp_stall);
        check_val("flush_events_hold", int'(flush_events), exp_flush);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
